// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// counter sizing and width-derived constants.
package divisor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Widest operand the constant helpers below can describe.
    localparam int MAX_W = 64;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Iteration counter must hold the value WIDTH itself.
    function automatic int cnt_w(input int width);
        return clog2(width + 1);
    endfunction

    // All-ones pattern in the low 'width' bits (quotient on divide-by-zero).
    function automatic logic [MAX_W-1:0] ones_const(input int width);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < width; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Most negative two's-complement value of 'width' bits.
    function automatic logic [MAX_W-1:0] min_const(input int width);
        logic [MAX_W-1:0] v;
        v = '0;
        v[width-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/divisor_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module divisor_step
    import divisor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH-1:0] w_sh;
    logic [WIDTH-1:0] w_diff;

    assign w_sh   = {i_rem[WIDTH-2:0], i_bit};
    assign w_diff = w_sh - i_div;
    // When the remainder MSB is set the true shifted value is >= 2^WIDTH and
    // therefore exceeds any divisor; the WIDTH-bit wrapped difference is then
    // still the exact new remainder because that remainder is < divisor.
    assign o_q    = i_rem[WIDTH-1] | (w_sh >= i_div);
    assign o_rem  = o_q ? w_diff : w_sh;

endmodule

// File: rtl/divisor_seq.sv
// Multi-cycle restoring divider with start/busy/done handshake, optional
// two's-complement mode and divide-by-zero / overflow flags.
module divisor_seq
    import divisor_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] R,
    output logic             dbz,
    output logic             ovf
);

    localparam int               CW       = cnt_w(WIDTH);
    localparam logic [MAX_W-1:0] L_ONES_X = ones_const(WIDTH);
    localparam logic [MAX_W-1:0] L_MIN_X  = min_const(WIDTH);
    localparam logic [WIDTH-1:0] L_ONES   = L_ONES_X[WIDTH-1:0];
    localparam logic [WIDTH-1:0] L_MIN    = L_MIN_X[WIDTH-1:0];
    localparam logic             L_SGN    = (SIGNED != 0);

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;     // dividend shifts out MSB-first, quotient fills from LSB
    logic [WIDTH-1:0] r_dsr;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_ovf_pend;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_r;
    logic             r_dbz;
    logic             r_ovf;

    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_amag;
    logic [WIDTH-1:0] w_bmag;
    logic             w_ovf_det;
    logic [WIDTH-1:0] w_rem;
    logic             w_q;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_s_fin;
    logic [WIDTH-1:0] w_r_fin;

    // Operand signs are forced to zero in unsigned mode, so the magnitude
    // path collapses to a plain copy. |MIN| = 2^(WIDTH-1) fits unsigned.
    assign w_sa      = L_SGN & A[WIDTH-1];
    assign w_sb      = L_SGN & B[WIDTH-1];
    assign w_amag    = w_sa ? -A : A;
    assign w_bmag    = w_sb ? -B : B;
    assign w_ovf_det = L_SGN & (A == L_MIN) & (B == L_ONES);

    divisor_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_bit (r_dvd[WIDTH-1]),
        .i_div (r_dsr),
        .o_rem (w_rem),
        .o_q   (w_q)
    );

    // Final quotient/remainder of the last step, with sign fix folded in so
    // the FIN cycle costs nothing extra.
    assign w_quot  = {r_dvd[WIDTH-2:0], w_q};
    assign w_s_fin = r_neg_q ? -w_quot : w_quot;
    assign w_r_fin = r_neg_r ? -w_rem : w_rem;

    assign busy = r_busy;
    assign done = r_done;
    assign S    = r_s;
    assign R    = r_r;
    assign dbz  = r_dbz;
    assign ovf  = r_ovf;

    // Control FSM and datapath registers; FIN also accepts a new start so
    // back-to-back divisions lose no cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_dsr      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_s        <= '0;
            r_r        <= '0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (start) begin
                        r_s        <= '0;
                        r_r        <= '0;
                        r_dbz      <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_neg_q    <= w_sa ^ w_sb;
                        r_neg_r    <= w_sa;
                        r_ovf_pend <= w_ovf_det;
                        if (B == '0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                            r_s     <= L_ONES;
                            r_r     <= A;
                            r_dbz   <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_cnt   <= CW'(WIDTH);
                            r_rem   <= '0;
                            r_dvd   <= w_amag;
                            r_dsr   <= w_bmag;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_rem <= w_rem;
                    r_dvd <= w_quot;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_s     <= w_s_fin;
                        r_r     <= w_r_fin;
                        r_ovf   <= r_ovf_pend;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/divisor_seq.md
Name: divisor_seq

Overview:
- Parametrised multi-cycle restoring divider, successor to the 4-bit divisor.
- Computes quotient and remainder of WIDTH-bit operands, one quotient bit per clock.
- Adds a start/busy/done handshake, optional signed mode, and divide-by-zero and overflow flags.
- Sits in the datapath next to the ALU blocks; operands arrive from the input registers, results go to the display/output stage.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands, truncating division

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  request a division; accepted only when busy=0
A  input  WIDTH  dividend, sampled on the accepting edge
B  input  WIDTH  divisor, sampled on the accepting edge
busy  output  1  division in progress; start is ignored while high
done  output  1  one-cycle pulse: S/R/flags valid from this cycle
S  output  WIDTH  quotient, held until the next accepted start
R  output  WIDTH  remainder, held until the next accepted start
dbz  output  1  last division had B=0
ovf  output  1  last division was signed MIN/-1 (SIGNED=1 only; tied 0 otherwise)

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, S=0, R=0, dbz=0, ovf=0, iteration counter=0.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start=1 -> latch |A|, |B|, result signs, clear S/R/flags.
    - B!=0 -> RUN, counter=WIDTH.
    - B=0 -> FIN directly.
  - RUN: one restoring step per edge.
    - rem = {rem[W-2:0], dvd_msb} - divisor.
    - If non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
    - Counter decrements; at counter=1 -> FIN.
  - FIN: one cycle. done=1, outputs S/R/flags updated; next state IDLE.
- Handshake and timing (start high in cycle 0, B!=0):
  - busy=1 in cycles 1..WIDTH.
  - done=1 and results valid in cycle WIDTH+1.
  - Accepting a new start in cycle WIDTH+1 is legal because busy=0 then.
- Divide by zero:
  - done in cycle 1; dbz=1; S=all ones; R=A (unmodified bits).
  - ovf=0.
- Signed mode (SIGNED=1):
  - Divide magnitudes, then negate S if sign(A)^sign(B).
  - R takes the sign of A; |R| < |B|.
  - Sign fix is applied when registering results in FIN; it adds no cycle.
  - A=MIN, B=-1: S=MIN (wraps), R=0, ovf=1.
  - Magnitude of MIN is represented in WIDTH bits unsigned (2^(W-1)); no internal overflow.
- start while busy=1: ignored. Operands and state are unaffected.
- start held high: a new division is accepted every time busy=0 (back-to-back).
- A/B changing during RUN: no effect, because the operands were latched at accept.
- reset asserted mid-RUN: immediate abort to the reset values above; no done pulse.
- done is never asserted without a preceding accepted start.

Decomposition:
- Package divisor_pkg:
  - FSM state encoding (IDLE, RUN, FIN, 2-bit).
  - Counter width function clog2(WIDTH+1).
  - Localparams for the all-ones and MIN constants derived from WIDTH.
- Sub-module divisor_step: combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
  - Parametrised by WIDTH and instantiated once in divisor_seq.

Test Plan:
- WIDTH=8, SIGNED=0, A=100, B=7, start pulse cycle 0 -> busy cycles 1-8, done cycle 9, S=14, R=2, dbz=0.
- WIDTH=8, A=5, B=0 -> done cycle 1, dbz=1, S=8'hFF, R=5; then start A=255, B=16 accepted in that cycle -> S=15, R=15, dbz=0.
- WIDTH=8, SIGNED=1: A=-7, B=2 -> S=-3 (8'hFD), R=-1 (8'hFF); A=-128, B=-1 -> S=8'h80, R=0, ovf=1.
- Start at cycle 0 with A=200, B=3; start pulses again at cycles 3 and 5 with A=9, B=9 -> ignored; done cycle 9 with S=66, R=2.
- reset driven low during cycle 4 of a run -> busy, done, S, R, flags go 0 asynchronously; no done afterwards; next division 50/5 gives S=10, R=0.
- WIDTH=4, SIGNED=0, A=15, B=15 -> done cycle 5, S=1, R=0; A=3, B=7 -> S=0, R=3.
